// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the FSM state encoding, the RV32M funct3 codes and the special-case constants.
// Imported by md_special_chk and md_sched.
package md_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_WAIT = 3'd2,
        ST_BYP      = 3'd3,
        ST_DONE_MUL = 3'd4,
        ST_DONE_DIV = 3'd5
    } md_state_e;

    // RV32M funct3 encodings
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Architectural results for the cases the divider is never asked to compute
    localparam logic [31:0] DIVZ_QUOT    = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// Bundle between the execute stage / MD units and the MD sequencer.
// master: pipeline side (drives request, operands, flush); slave: md_sched.
// Carries no clock or reset; those stay plain ports on the sequencer.
interface md_sched_if;

    logic        md_req;
    logic [2:0]  md_funct3;
    logic [31:0] md_op1;
    logic [31:0] md_op2;
    logic        flush;

    logic        mul_start;
    logic        div_start;
    logic        unit_kill;
    logic        md_stall;
    logic        ex2mem_mulvalid;
    logic        div2mem_divvalid;
    logic        md_bypass_valid;
    logic [31:0] md_bypass_wdata;
    logic        md_busy;

    modport master (
        output md_req, md_funct3, md_op1, md_op2, flush,
        input  mul_start, div_start, unit_kill, md_stall,
               ex2mem_mulvalid, div2mem_divvalid,
               md_bypass_valid, md_bypass_wdata, md_busy
    );

    modport slave (
        input  md_req, md_funct3, md_op1, md_op2, flush,
        output mul_start, div_start, unit_kill, md_stall,
               ex2mem_mulvalid, div2mem_divvalid,
               md_bypass_valid, md_bypass_wdata, md_busy
    );

endinterface

// File: rtl/md_special_chk.sv
// Purpose: detects divide-by-zero and signed overflow and produces the architectural result.
// Latency: purely combinational. Backpressure: none.
// Ports: funct3/op1/op2 in; is_special, special_wdata[31:0] out.
module md_special_chk
    import md_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        is_special,
    output logic [31:0] special_wdata
);

    logic divz;
    logic ovf;

    assign divz = (op2 == 32'd0);
    assign ovf  = (op1 == OVF_DIVIDEND) && (op2 == OVF_DIVISOR);

    // Divide-by-zero is tested first so it wins over overflow.
    always_comb begin
        is_special    = 1'b0;
        special_wdata = 32'd0;
        case (funct3)
            MD_DIV: begin
                if (divz) begin
                    is_special    = 1'b1;
                    special_wdata = DIVZ_QUOT;
                end else if (ovf) begin
                    is_special    = 1'b1;
                    special_wdata = OVF_DIVIDEND;
                end
            end
            MD_DIVU: begin
                if (divz) begin
                    is_special    = 1'b1;
                    special_wdata = DIVZ_QUOT;
                end
            end
            MD_REM: begin
                if (divz) begin
                    is_special    = 1'b1;
                    special_wdata = op1;
                end else if (ovf) begin
                    is_special    = 1'b1;
                    special_wdata = 32'd0;
                end
            end
            MD_REMU: begin
                if (divz) begin
                    is_special    = 1'b1;
                    special_wdata = op1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Purpose: sequences the external multiplier/divider and stalls the front end for their latency.
// Latency: result flag MUL_LAT / DIV_LAT cycles after accept, 1 cycle for special-case bypass.
// Backpressure: md_stall holds PC, IF/ID and de2ex from accept until the result cycle.
// Ports: clk, rst (sync, active-high); md (md_sched_if.slave) carries request, operands, flush,
//        unit launch/kill, stall, result-valid flags and bypass data.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 33,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    md_sched_if.slave   md
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       byp_wdata_q, byp_wdata_d;

    logic              is_special;
    logic [31:0]       special_wdata;
    logic              accept;
    logic              kill;

    md_special_chk u_special_chk (
        .funct3        (md.md_funct3),
        .op1           (md.md_op1),
        .op2           (md.md_op2),
        .is_special    (is_special),
        .special_wdata (special_wdata)
    );

    // reset behaves as a flush for the current cycle's outputs
    assign kill   = md.flush || rst;
    assign accept = (state_q == ST_IDLE) && md.md_req && !kill;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            byp_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byp_wdata_q <= byp_wdata_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byp_wdata_d = byp_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div_op(md.md_funct3)) begin
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        state_d = (MUL_LAT == 1) ? ST_DONE_MUL : ST_MUL_WAIT;
                    end else if (is_special) begin
                        byp_wdata_d = special_wdata;
                        state_d     = ST_BYP;
                    end else begin
                        cnt_d   = CNT_W'(DIV_LAT - 1);
                        state_d = (DIV_LAT == 1) ? ST_DONE_DIV : ST_DIV_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE_MUL;
            end
            ST_DIV_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE_DIV;
            end
            ST_BYP, ST_DONE_MUL, ST_DONE_DIV: begin
                // md_req seen here belongs to the next instruction; it is evaluated in IDLE
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (md.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // ---------------- outputs ----------------
    // Accept-cycle start pulses and stall are combinational from the request so the
    // unit launches in the same cycle the instruction sits in de2ex.
    always_comb begin
        md.mul_start        = accept && !is_div_op(md.md_funct3);
        md.div_start        = accept && is_div_op(md.md_funct3) && !is_special;
        md.md_stall         = accept ||
                              (((state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT)) && !kill);
        md.ex2mem_mulvalid  = (state_q == ST_DONE_MUL) && !kill;
        md.div2mem_divvalid = (state_q == ST_DONE_DIV) && !kill;
        md.md_bypass_valid  = (state_q == ST_BYP) && !kill;
        md.md_bypass_wdata  = byp_wdata_q;
        // units are reset along with us, so no explicit abort under rst
        md.unit_kill        = md.flush && !rst && (state_q != ST_IDLE);
        md.md_busy          = (state_q != ST_IDLE) && !rst;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencer for the multi-cycle multiply/divide resources used by the execute stage.
- Accepts an MD instruction held in the de2ex register, launches the external multiplier or divider, and stalls the front of the pipeline for the fixed unit latency.
- Raises the one-cycle result-valid flags consumed by the execute write-data mux.
- Resolves divide-by-zero and signed-overflow locally as a 1-cycle bypass, without starting the divider.

Parameters:
- MUL_LAT, 2, cycles from mul_start to multiplier result ready; legal range 1..63.
- DIV_LAT, 33, cycles from div_start to divider result ready; legal range 1..63.
- CNT_W, 6, width of the latency down-counter; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- md_req  in  1  de2ex_MD_OP_ffout & de2ex_inst_valid_ffout; stays high while the instruction is stalled.
- md_funct3  in  3  RV32M funct3: 0-3 MUL/MULH/MULHSU/MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- md_op1  in  32  rs1 operand.
- md_op2  in  32  rs2 operand.
- flush  in  1  pipeline kill of the in-flight instruction.
- mul_start  out  1  one-cycle launch pulse to the multiplier.
- div_start  out  1  one-cycle launch pulse to the divider.
- unit_kill  out  1  abort to both units; equals flush while the state is not IDLE.
- md_stall  out  1  freezes PC, IF/ID and de2ex.
- ex2mem_mulvalid  out  1  multiplier result valid this cycle.
- div2mem_divvalid  out  1  divider result valid this cycle.
- md_bypass_valid  out  1  special-case result valid this cycle.
- md_bypass_wdata  out  32  special-case result.
- md_busy  out  1  state is not IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; bypass data register 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, BYP, DONE_MUL, DONE_DIV.
- IDLE with md_req=1 and flush=0 is the accept cycle:
  - funct3[2]=0: mul_start=1, md_stall=1, cnt=MUL_LAT-1, go to MUL_WAIT (or DONE_MUL if MUL_LAT=1).
  - funct3[2]=1 and special case: md_stall=1, register bypass data, go to BYP; div_start stays 0.
  - funct3[2]=1 otherwise: div_start=1, md_stall=1, cnt=DIV_LAT-1, go to DIV_WAIT (or DONE_DIV if DIV_LAT=1).
- Special cases:
  - op2==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op1.
  - Signed only (DIV/REM) with op1==0x80000000 and op2==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - Divide-by-zero takes priority over overflow.
- MUL_WAIT / DIV_WAIT: md_stall=1; cnt decrements each cycle; at cnt==1 go to the matching DONE state.
- DONE_MUL / DONE_DIV / BYP: the matching valid flag is 1 and md_stall=0, so the pipeline advances this cycle; next state is IDLE.
- Timing (accept = cycle 0):
  - Results valid in cycle MUL_LAT, DIV_LAT, or 1 for bypass.
  - md_stall is high in cycles 0..LAT-1.
- No re-launch: md_req is ignored in every non-IDLE state. The instruction held in de2ex after DONE is the next one and is evaluated in the following IDLE cycle.
- Back-to-back MD instructions: the minimum spacing between accept cycles is LAT+1.
- flush, any state:
  - Same cycle: md_stall=0, start pulses and valid flags forced to 0, unit_kill=1 if the state is not IDLE.
  - Next state: IDLE.
  - flush with md_req in IDLE causes no accept.
  - flush coincident with a DONE/BYP state suppresses the valid flag.
- rst mid-operation: same effect as flush, plus all registers cleared; unit_kill=0.
- Outputs are registered-state decodes. Start pulses and md_stall in the accept cycle are combinational from md_req, funct3 and the special-case check.

Decomposition:
- md_pkg holds:
  - the state encodings;
  - funct3 constants (MD_MUL..MD_REMU);
  - DIVZ_QUOT=32'hFFFFFFFF;
  - OVF_DIVIDEND=32'h80000000;
  - OVF_DIVISOR=32'hFFFFFFFF.
- One sub-module, md_special_chk (combinational): takes funct3, op1, op2 and outputs is_special and special_wdata[31:0].
- FSM and counter live in md_sched.

Test Plan:
- MUL (funct3=0), MUL_LAT=2, md_req at cycle 0:
  - mul_start=1 at cycle 0; md_stall=1 at cycles 0-1.
  - ex2mem_mulvalid=1 and md_stall=0 at cycle 2; IDLE at cycle 3.
- DIVU op1=100, op2=7, DIV_LAT=33:
  - div_start=1 at cycle 0; md_stall=1 at cycles 0-32.
  - div2mem_divvalid=1 at cycle 33 only.
- DIV op2=0 -> md_bypass_valid=1 at cycle 1, wdata=0xFFFFFFFF, div_start never 1. REMU op1=0x1234, op2=0 -> wdata=0x00001234.
- DIV op1=0x80000000, op2=0xFFFFFFFF -> bypass wdata=0x80000000. REM with the same operands -> 0. DIVU with the same operands -> normal divide path, div_start=1.
- DIV accepted, flush at cycle 10:
  - unit_kill=1 and md_stall=0 at cycle 10; IDLE at cycle 11.
  - No div2mem_divvalid through cycle 40.
  - A new MUL at cycle 11 is accepted.
- Back-to-back MUL, MUL (md_req held high across both): exactly two mul_start pulses at cycles 0 and 3 and two valids at cycles 2 and 5. rst at cycle 1 of a second run clears all outputs at cycle 2.
